dmem_port_arbiter: RTL

//  Shares data-memory port A (single-port view of the dual-port dmem; port B stays VGA read-only)

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_port_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port A arbiter.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (see dmem_port_arbiter).
package dmem_arb_pkg;
    localparam int MAX_N_REQ = 8;
    localparam int ID_W      = $clog2(MAX_N_REQ);

    // Wide enough for any legal N_REQ, so one encoding serves every instance.
    typedef logic [ID_W-1:0] id_t;

    // One read-return pipeline stage: is a read in flight, and whose is it.
    typedef struct packed {
        logic valid;
        id_t  id;
    } rd_tag_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side signals of the port A arbiter.
// slave: the arbiter's view. master: the requesters plus the memory.
interface dmem_port_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wd;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_rd;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rd,
        output gnt, rvalid, rdata, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rd,
        input  gnt, rvalid, rdata, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: lowest requesting index at or
// above ptr wins, wrapping to the lowest index below ptr. ptr = 0 gives
// plain fixed priority.
module rr_pick import dmem_arb_pkg::*; #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  id_t              ptr,
    output logic [N_REQ-1:0] gnt,
    output id_t              id,
    output logic             any
);

    // Two passes: upper segment [ptr..N_REQ-1] first, then the wrapped [0..ptr-1].
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (id_t'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                id     = id_t'(i);
                any    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (id_t'(i) < ptr)) begin
                gnt[i] = 1'b1;
                id     = id_t'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares dmem port A between N_REQ requesters (0 = CPU, 1 = DMA/loader).
// One access per clock; read data returns to its originator RD_LAT clocks
// after the access edge, in issue order.
// Build option DMEM_ARB_FIXED_PRIO_EN: fixed priority, requester 0 highest,
// no rotation pointer. Default: round-robin.
module dmem_port_arbiter import dmem_arb_pkg::*; #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    logic [N_REQ-1:0]  gnt_raw;
    logic              any_raw;
    logic              gnt_any;
    id_t               win_id;
    id_t               ptr_in;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wd_sel;
    rd_tag_t           pipe [RD_LAT];
    rd_tag_t           tail;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_in),
        .gnt (gnt_raw),
        .id  (win_id),
        .any (any_raw)
    );

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign ptr_in = '0;
`else
    id_t rr_ptr;

    // Rotation pointer: one past the last winner, held when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= (win_id == id_t'(N_REQ - 1)) ? '0 : win_id + id_t'(1);
    end

    assign ptr_in = rr_ptr;
`endif

    // Nothing may reach the memory while reset is held.
    assign gnt_any = any_raw & ~rst;
    assign bus.gnt = rst ? '0 : gnt_raw;

    // Route the winner's fields to the memory; requester 0 when idle.
    always_comb begin
        addr_sel = bus.req_addr[ADDR_W-1:0];
        wd_sel   = bus.req_wdata[DATA_W-1:0];
        we_sel   = bus.req_we[0];
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_raw[i]) begin
                addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
                wd_sel   = bus.req_wdata[i*DATA_W +: DATA_W];
                we_sel   = bus.req_we[i];
            end
        end
    end

    assign bus.mem_addr = addr_sel;
    assign bus.mem_wd   = wd_sel;
    assign bus.mem_we   = gnt_any & we_sel;

    // Read-return tags march alongside the memory latency; reset drops them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: gnt_any & ~we_sel, id: win_id};
            for (int i = 1; i < RD_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign tail      = pipe[RD_LAT-1];
    assign bus.rdata = bus.mem_rd;

    // Decode the returning tag to the originator's rvalid bit.
    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tail.valid && (tail.id == id_t'(i)))
                bus.rvalid[i] = 1'b1;
        end
    end

endmodule
